// File: rtl/hsv_core_commit.sv
// rtl/hsv_core_commit.sv - in-order commit/writeback stage with order-token FIFO and redirect flush handshake
module hsv_core_commit #(
    parameter int ORDER_DEPTH = 8
) (
    input  logic        clk_core,
    input  logic        rst_core,
    input  logic        order_valid_i,
    output logic        order_ready_o,
    input  logic [1:0]  order_unit,
    input  logic        alu_valid_i,
    output logic        alu_ready_o,
    input  logic [4:0]  alu_rd_addr,
    input  logic [31:0] alu_rd_value,
    input  logic        alu_wr_req,
    input  logic        branch_valid_i,
    output logic        branch_ready_o,
    input  logic [4:0]  branch_rd_addr,
    input  logic [31:0] branch_rd_value,
    input  logic        branch_wr_req,
    input  logic        branch_redirect,
    input  logic [31:0] branch_target,
    input  logic        ctrl_status_valid_i,
    output logic        ctrl_status_ready_o,
    input  logic [4:0]  ctrl_status_rd_addr,
    input  logic [31:0] ctrl_status_rd_value,
    input  logic        ctrl_status_wr_req,
    input  logic        ctrl_status_redirect,
    input  logic [31:0] ctrl_status_target,
    input  logic        mem_valid_i,
    output logic        mem_ready_o,
    input  logic [4:0]  mem_rd_addr,
    input  logic [31:0] mem_rd_value,
    input  logic        mem_wr_req,
    output logic [4:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic        wr_en,
    output logic [31:0] commit_mask,
    output logic        flush_req,
    input  logic        flush_ack,
    output logic [31:0] flush_target
);

    localparam int PW = $clog2(ORDER_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = ORDER_DEPTH[CW-1:0];

    localparam logic [0:0] ST_RUN        = 1'b0;
    localparam logic [0:0] ST_FLUSH_WAIT = 1'b1;

    localparam logic [1:0] U_ALU  = 2'd0;
    localparam logic [1:0] U_BR   = 2'd1;
    localparam logic [1:0] U_CSR  = 2'd2;
    localparam logic [1:0] U_MEM  = 2'd3;

    logic [1:0]    tok_mem [ORDER_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic [0:0]    state;

    logic [1:0]  head;
    logic        head_ok, push, pop, redirect_retire;
    logic        sel_valid, sel_req, sel_redirect;
    logic [4:0]  sel_addr;
    logic [31:0] sel_value, sel_target;

    // Readies are gated by reset so nothing is offered while the core is held
    assign head    = tok_mem[rd_ptr];
    assign head_ok = !rst_core && (state == ST_RUN) && (count != '0);

    assign order_ready_o       = !rst_core && (state == ST_RUN) && (count != DEPTH_C);
    assign alu_ready_o         = head_ok && (head == U_ALU);
    assign branch_ready_o      = head_ok && (head == U_BR);
    assign ctrl_status_ready_o = head_ok && (head == U_CSR);
    assign mem_ready_o         = head_ok && (head == U_MEM);

    always_comb begin
        sel_valid    = alu_valid_i;
        sel_addr     = alu_rd_addr;
        sel_value    = alu_rd_value;
        sel_req      = alu_wr_req;
        sel_redirect = 1'b0;
        sel_target   = branch_target;
        case (head)
            U_BR: begin
                sel_valid    = branch_valid_i;
                sel_addr     = branch_rd_addr;
                sel_value    = branch_rd_value;
                sel_req      = branch_wr_req;
                sel_redirect = branch_redirect;
                sel_target   = branch_target;
            end
            U_CSR: begin
                sel_valid    = ctrl_status_valid_i;
                sel_addr     = ctrl_status_rd_addr;
                sel_value    = ctrl_status_rd_value;
                sel_req      = ctrl_status_wr_req;
                sel_redirect = ctrl_status_redirect;
                sel_target   = ctrl_status_target;
            end
            U_MEM: begin
                sel_valid    = mem_valid_i;
                sel_addr     = mem_rd_addr;
                sel_value    = mem_rd_value;
                sel_req      = mem_wr_req;
            end
            default: ;
        endcase
    end

    assign push            = order_valid_i && order_ready_o;
    assign pop             = head_ok && sel_valid;
    assign redirect_retire = pop && sel_redirect;

    always_ff @(posedge clk_core) begin
        if (push) begin
            tok_mem[wr_ptr] <= order_unit;
        end
    end

    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            state        <= ST_RUN;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            commit_mask  <= '0;
            flush_req    <= 1'b0;
            flush_target <= '0;
        end else begin
            wr_en       <= pop && sel_req && (sel_addr != 5'd0);
            commit_mask <= (pop && sel_req && (sel_addr != 5'd0)) ? (32'h1 << sel_addr) : 32'h0;
            if (pop) begin
                wr_addr <= sel_addr;
                wr_data <= sel_value;
                rd_ptr  <= rd_ptr + 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            count <= count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};

            if (state == ST_RUN) begin
                if (redirect_retire) begin
                    state        <= ST_FLUSH_WAIT;
                    flush_req    <= 1'b1;
                    flush_target <= sel_target;
                end
            end else if (flush_ack) begin
                // Younger tokens belong to the squashed path; drop them all
                state     <= ST_RUN;
                flush_req <= 1'b0;
                rd_ptr    <= '0;
                wr_ptr    <= '0;
                count     <= '0;
            end
        end
    end

endmodule
